// File: rtl/friet_xaon_inverse_core_if.sv
// Handshake bundle for the Friet XAON inverse core: one input and one output channel of three limbs.
// A channel transfers on a rising clk edge where valid and ready are both high; the sender holds valid and data stable until then.
interface friet_xaon_inverse_core_if #(
   parameter int W = 128
);
   logic         din_valid;
   logic         din_ready;
   logic [W-1:0] din_a;
   logic [W-1:0] din_b;
   logic [W-1:0] din_c;
   logic         dout_valid;
   logic         dout_ready;
   logic [W-1:0] dout_a;
   logic [W-1:0] dout_b;
   logic [W-1:0] dout_c;

   modport master (
      output din_valid, din_a, din_b, din_c, dout_ready,
      input  din_ready, dout_valid, dout_a, dout_b, dout_c
   );

   modport slave (
      input  din_valid, din_a, din_b, din_c, dout_ready,
      output din_ready, dout_valid, dout_a, dout_b, dout_c
   );
endinterface

// File: rtl/friet_xaon_inverse_core.sv
// Iterative inverse of the coded XAON round stack: one inverse round per clock,
// round index ROUNDS-1 down to 0, so forward-then-inverse is the identity.
module friet_xaon_inverse_core #(
   parameter int W      = 128,
   parameter int ROUNDS = 24,
   parameter int R1     = 1,
   parameter int R2     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   friet_xaon_inverse_core_if.slave    bus,
   output logic                        busy,
   output logic [1:0]                  dbg_state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(ROUNDS - 1);
   // Right-shift amounts completing each rotation; modulo keeps a zero rotation well defined.
   localparam int S1 = (W - R1) % W;
   localparam int S2 = (W - R2) % W;

   state_t       state;
   state_t       state_nx;
   logic [W-1:0] a_q;
   logic [W-1:0] b_q;
   logic [W-1:0] c_q;
   logic [7:0]   idx_q;
   logic [W-1:0] rot_b;
   logic [W-1:0] rot_c;
   logic [W-1:0] rc;
   logic [W-1:0] new_c;

   // The held state (a_q, b_q, c_q) plays the role of (x, y, z) for the round being undone.
   assign rot_b = (b_q << R1) | (b_q >> S1);
   assign rot_c = (c_q << R2) | (c_q >> S2);
   assign rc    = {{(W-8){1'b0}}, idx_q};
   assign new_c = (rot_b & rot_c) ^ a_q ^ rc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.din_valid) state_nx = RUN;
         RUN:     if (idx_q == 8'd0) state_nx = DONE;
         DONE:    if (bus.dout_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         c_q   <= '0;
         idx_q <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.din_valid) begin
                  a_q   <= bus.din_a;
                  b_q   <= bus.din_b;
                  c_q   <= bus.din_c;
                  idx_q <= LAST_IDX;
               end
            end
            RUN: begin
               a_q <= b_q;
               b_q <= c_q;
               c_q <= new_c;
               if (idx_q != 8'd0) idx_q <= idx_q - 8'd1;
            end
            default: ;
         endcase
      end
   end

   // din_ready is masked by rst so nothing appears acceptable during the reset cycle itself.
   assign bus.din_ready  = (state == IDLE) && !rst;
   assign bus.dout_valid = (state == DONE);
   assign bus.dout_a     = a_q;
   assign bus.dout_b     = b_q;
   assign bus.dout_c     = c_q;
   assign busy           = (state == RUN) || (state == DONE);
   assign dbg_state      = state;

endmodule

// File: tb/tb_friet_xaon_inverse_core.sv
// Bench for friet_xaon_inverse_core: fixed vectors on small instances, and a forward
// round model feeding the default instance whose results must reproduce the original state.
module tb_friet_xaon_inverse_core;

   localparam int MW = 128;
   localparam int MR = 24;

   logic clk;
   logic rst;
   int   cyc;
   int   n_tests;
   int   n_fail;
   bit   rand_rdy;

   logic        busy_m, busy_s2, busy_s1;
   logic [1:0]  dbg_m, dbg_s2, dbg_s1;

   logic [3*MW-1:0] exp_q[$];

   friet_xaon_inverse_core_if #(.W(MW)) bus_m ();
   friet_xaon_inverse_core_if #(.W(16)) bus_s2 ();
   friet_xaon_inverse_core_if #(.W(16)) bus_s1 ();

   friet_xaon_inverse_core #(.W(MW), .ROUNDS(MR), .R1(1), .R2(8)) dut_m (
      .clk(clk), .rst(rst), .bus(bus_m), .busy(busy_m), .dbg_state(dbg_m)
   );
   friet_xaon_inverse_core #(.W(16), .ROUNDS(2), .R1(1), .R2(8)) dut_s2 (
      .clk(clk), .rst(rst), .bus(bus_s2), .busy(busy_s2), .dbg_state(dbg_s2)
   );
   friet_xaon_inverse_core #(.W(16), .ROUNDS(1), .R1(1), .R2(8)) dut_s1 (
      .clk(clk), .rst(rst), .bus(bus_s1), .busy(busy_s1), .dbg_state(dbg_s1)
   );

   // Both small instances see the same input stimulus and always take their result.
   assign bus_s1.din_valid  = bus_s2.din_valid;
   assign bus_s1.din_a      = bus_s2.din_a;
   assign bus_s1.din_b      = bus_s2.din_b;
   assign bus_s1.din_c      = bus_s2.din_c;
   assign bus_s1.dout_ready = 1'b1;
   assign bus_s2.dout_ready = 1'b1;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [MW-1:0] rotl(input logic [MW-1:0] v, input int r);
      logic [MW-1:0] o;
      for (int k = 0; k < MW; k++) o[(k + r) % MW] = v[k];
      return o;
   endfunction

   // Forward Friet XAON rounds 0..MR-1: t = (a<<<1 & b<<<8) ^ c ^ rc(i); state = (t, a, b).
   function automatic logic [3*MW-1:0] fwd(input logic [3*MW-1:0] s);
      logic [MW-1:0] a, b, c, t;
      {a, b, c} = s;
      for (int i = 0; i < MR; i++) begin
         t = (rotl(a, 1) & rotl(b, 8)) ^ c ^ MW'(8'(i));
         c = b;
         b = a;
         a = t;
      end
      return {a, b, c};
   endfunction

   function automatic logic [3*MW-1:0] rand_state();
      logic [3*MW-1:0] s;
      for (int k = 0; k < 12; k++) s[k*32 +: 32] = $urandom();
      return s;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && bus_m.dout_valid && bus_m.dout_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %h with nothing expected",
                     {bus_m.dout_a, bus_m.dout_b, bus_m.dout_c});
         end else begin
            check("result", 400'({bus_m.dout_a, bus_m.dout_b, bus_m.dout_c}), 400'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) bus_m.dout_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [3*MW-1:0] s, input bit keep, output int acc);
      int n;
      {bus_m.din_a, bus_m.din_b, bus_m.din_c} = s;
      bus_m.din_valid = 1'b1;
      n = 0;
      acc = -1;
      while (!bus_m.din_ready && n < 200) begin
         tick();
         n++;
      end
      if (!bus_m.din_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: din_ready stayed %b for %0d cycles, required 1", bus_m.din_ready, n);
      end else begin
         tick();
         acc = cyc;
      end
      if (!keep) bus_m.din_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      check(name, 400'(exp_q.size()), 400'(0));
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [15:0] a, b, c;
      logic [47:0] exp2;
      logic [47:0] exp1;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [3*MW-1:0] orig;
      logic [47:0]     r1, r2;
      int              lat1, lat2, lat, acc, prev_acc, n;
      bit              got1, got2;

      vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 48'h0000_0001_0000, 48'h0000_0000_0000};
      vecs[1] = '{16'h0000, 16'hFFFF, 16'hFFFF, 48'hFFFF_FFFE_0100, 48'hFFFF_FFFF_FFFF};
      vecs[2] = '{16'h1234, 16'h0000, 16'h0000, 48'h0000_1235_0000, 48'h0000_0000_1234};
      vecs[3] = '{16'h0003, 16'h8001, 16'h0100, 48'h0100_0003_8201, 48'h8001_0100_0002};
      vecs[4] = '{16'hAAAA, 16'h5555, 16'h00FF, 48'h00FF_00AB_5455, 48'h5555_00FF_00AA};

      n_tests = 0;
      n_fail = 0;
      rand_rdy = 1'b0;
      rst = 1'b1;
      bus_m.din_valid = 1'b0;
      bus_m.din_a = '0;
      bus_m.din_b = '0;
      bus_m.din_c = '0;
      bus_m.dout_ready = 1'b1;
      bus_s2.din_valid = 1'b0;
      bus_s2.din_a = '0;
      bus_s2.din_b = '0;
      bus_s2.din_c = '0;

      // Reset state.
      tick();
      tick();
      check("reset_outputs", 400'({bus_m.din_ready, bus_m.dout_valid, busy_m,
                                   bus_m.dout_a, bus_m.dout_b, bus_m.dout_c}), 400'(0));
      rst = 1'b0;
      tick();
      check("ready_after_reset", 400'({bus_m.din_ready, bus_s2.din_ready, bus_s1.din_ready}), 400'(3'b111));

      // Table vectors on the W=16 instances (ROUNDS=2 and ROUNDS=1).
      for (int v = 0; v < 5; v++) begin
         bus_s2.din_a = vecs[v].a;
         bus_s2.din_b = vecs[v].b;
         bus_s2.din_c = vecs[v].c;
         bus_s2.din_valid = 1'b1;
         check("small_idle", 400'({bus_s2.din_ready, bus_s1.din_ready}), 400'(2'b11));
         tick();
         bus_s2.din_valid = 1'b0;
         got1 = 1'b0;
         got2 = 1'b0;
         lat1 = 0;
         lat2 = 0;
         r1 = '0;
         r2 = '0;
         for (int k = 1; k <= 6; k++) begin
            tick();
            if (bus_s1.dout_valid && !got1) begin
               got1 = 1'b1;
               lat1 = k;
               r1 = {bus_s1.dout_a, bus_s1.dout_b, bus_s1.dout_c};
            end
            if (bus_s2.dout_valid && !got2) begin
               got2 = 1'b1;
               lat2 = k;
               r2 = {bus_s2.dout_a, bus_s2.dout_b, bus_s2.dout_c};
            end
         end
         check("r1_result", 400'(r1), 400'(vecs[v].exp1));
         check("r1_latency", 400'(lat1), 400'(1));
         check("r2_result", 400'(r2), 400'(vecs[v].exp2));
         check("r2_latency", 400'(lat2), 400'(2));
      end

      // Random states through forward model then inverse core, with random output backpressure.
      rand_rdy = 1'b1;
      for (int j = 0; j < 1000; j++) begin
         orig = rand_state();
         exp_q.push_back(orig);
         send(fwd(orig), 1'b0, acc);
      end
      drain("random_drain");
      rand_rdy = 1'b0;
      bus_m.dout_ready = 1'b1;
      tick();

      // Backpressure in DONE, with an ignored din_valid pulse.
      bus_m.dout_ready = 1'b0;
      orig = rand_state();
      exp_q.push_back(orig);
      send(fwd(orig), 1'b0, acc);
      lat = 0;
      while (!bus_m.dout_valid && lat < 100) begin
         tick();
         lat++;
      end
      check("main_latency", 400'(lat), 400'(MR));
      for (int k = 0; k < 10; k++) begin
         check("bp_hold", 400'({bus_m.dout_valid, bus_m.din_ready, busy_m,
                                bus_m.dout_a, bus_m.dout_b, bus_m.dout_c}),
               400'({1'b1, 1'b0, 1'b1, orig}));
         if (k == 3) begin
            {bus_m.din_a, bus_m.din_b, bus_m.din_c} = rand_state();
            bus_m.din_valid = 1'b1;
         end else begin
            bus_m.din_valid = 1'b0;
         end
         tick();
      end
      bus_m.din_valid = 1'b0;
      bus_m.dout_ready = 1'b1;
      tick();
      check("bp_release", 400'({bus_m.din_ready, bus_m.dout_valid, busy_m, 32'(exp_q.size())}),
            400'({1'b1, 1'b0, 1'b0, 32'd0}));

      // Reset in the third RUN cycle aborts the job.
      orig = rand_state();
      send(fwd(orig), 1'b0, acc);
      check("run_busy", 400'({busy_m, bus_m.dout_valid, bus_m.din_ready}), 400'(3'b100));
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("abort_outputs", 400'({bus_m.din_ready, bus_m.dout_valid, busy_m,
                                   bus_m.dout_a, bus_m.dout_b, bus_m.dout_c}), 400'(0));
      rst = 1'b0;
      tick();
      check("abort_ready", 400'({bus_m.din_ready, busy_m}), 400'(2'b10));
      orig = rand_state();
      exp_q.push_back(orig);
      send(fwd(orig), 1'b0, acc);
      drain("fresh_job_drain");

      // Back-to-back with din_valid and dout_ready held high.
      bus_m.dout_ready = 1'b1;
      prev_acc = -1;
      for (int j = 0; j < 4; j++) begin
         orig = rand_state();
         exp_q.push_back(orig);
         send(fwd(orig), 1'b1, acc);
         if (j > 0) check("b2b_spacing", 400'(acc - prev_acc), 400'(MR + 2));
         prev_acc = acc;
      end
      bus_m.din_valid = 1'b0;
      drain("b2b_drain");

      n = 0;
      repeat (5) tick();
      check("final_queue", 400'(exp_q.size()), 400'(n));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
